// File: rtl/tictactoe_text_overlay_if.sv
// Character-buffer write port of the TicTacToe text overlay.
// The master drives write strobes; the overlay answers with a one-cycle error pulse.
interface tictactoe_text_overlay_if;
  logic       wr_en;
  logic [2:0] wr_line;
  logic [4:0] wr_col;
  logic [6:0] wr_char;
  logic       wr_err;

  modport master (output wr_en, wr_line, wr_col, wr_char, input wr_err);
  modport slave  (input wr_en, wr_line, wr_col, wr_char, output wr_err);
endinterface

// File: rtl/tictactoe_text_overlay.sv
// Multi-line text painter for the TicTacToe VGA display.
// Two-stage pixel pipeline: stage 1 looks up the character and addresses the
// font ROM, stage 2 turns the returned font row into text_on/text_rgb with
// per-line colour, per-line blink and an inverted-video cursor cell.
module tictactoe_text_overlay #(
  parameter int N_LINES        = 2,
  parameter int CHARS_PER_LINE = 16,
  parameter int SCALE_LOG2     = 1,
  parameter int ORIGIN_X       = 0,
  parameter int ORIGIN_Y       = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixel_tick,
  input  logic [9:0]               pix_x,
  input  logic [9:0]               pix_y,
  input  logic                     clk1Hz,
  tictactoe_text_overlay_if.slave  wr_bus,
  input  logic [3*N_LINES-1:0]     line_rgb,
  input  logic [N_LINES-1:0]       line_blink,
  input  logic                     cur_en,
  input  logic [2:0]               cur_line,
  input  logic [4:0]               cur_col,
  input  logic [7:0]               font_word,
  output logic [10:0]              rom_addr,
  output logic                     text_on,
  output logic [2:0]               text_rgb
);

  localparam int          CELL_W = 8 << SCALE_LOG2;
  localparam int          CELL_H = 16 << SCALE_LOG2;
  localparam logic [11:0] WIN_W  = 12'(CHARS_PER_LINE * CELL_W);
  localparam logic [11:0] WIN_H  = 12'(N_LINES * CELL_H);
  localparam logic [10:0] ORG_X  = 11'(ORIGIN_X);
  localparam logic [10:0] ORG_Y  = 11'(ORIGIN_Y);
  localparam logic [6:0]  SPACE  = 7'h20;

  // Character buffer and write error flag
  logic [6:0] char_q [N_LINES][CHARS_PER_LINE];
  logic [6:0] char_d [N_LINES][CHARS_PER_LINE];
  logic       wr_err_q, wr_err_d;
  logic       wr_ok;

  // Blink synchroniser, edge detector and phase
  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, phase_q, phase_d;

  // Stage 1 registers
  logic        s1_valid_q, s1_valid_d;
  logic        s1_in_win_q, s1_in_win_d;
  logic [2:0]  s1_line_q, s1_line_d;
  logic [2:0]  s1_bit_q, s1_bit_d;
  logic        s1_cur_q, s1_cur_d;
  logic [10:0] rom_addr_q, rom_addr_d;

  // Stage 2 registers
  logic       text_on_q, text_on_d;
  logic [2:0] text_rgb_q, text_rgb_d;

  // Stage 1 combinational helpers
  logic [10:0] dx, dy;
  logic        in_win;
  logic [4:0]  col;
  logic [2:0]  line;
  logic [3:0]  row;
  logic [2:0]  bit_idx;
  logic [6:0]  rd_char;

  // Stage 2 combinational helpers
  logic [2:0]  lcol;
  logic        blink_en;
  logic        font_bit;

  // Decode a write request: accept in-range writes, flag out-of-range ones
  always_comb begin
    wr_ok    = wr_bus.wr_en && (int'(wr_bus.wr_line) < N_LINES) &&
               (int'(wr_bus.wr_col) < CHARS_PER_LINE);
    wr_err_d = wr_bus.wr_en && !wr_ok;
    char_d   = char_q;
    for (int l = 0; l < N_LINES; l++)
      for (int c = 0; c < CHARS_PER_LINE; c++)
        if (wr_ok && wr_bus.wr_line == 3'(l) && wr_bus.wr_col == 5'(c))
          char_d[l][c] = wr_bus.wr_char;
  end

  // Detect rising edges of the synchronised 1 Hz reference and flip the phase
  always_comb begin
    sync1_d = clk1Hz;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    phase_d = phase_q ^ (sync2_q & ~prev_q);
  end

  // Map the pixel into window coordinates and fetch the character under it
  always_comb begin
    dx      = {1'b0, pix_x} - ORG_X;
    dy      = {1'b0, pix_y} - ORG_Y;
    in_win  = ({1'b0, pix_x} >= ORG_X) && ({1'b0, dx} < WIN_W) &&
              ({1'b0, pix_y} >= ORG_Y) && ({1'b0, dy} < WIN_H);
    col     = 5'(dx >> (3 + SCALE_LOG2));
    line    = 3'(dy >> (4 + SCALE_LOG2));
    row     = 4'(dy >> SCALE_LOG2);
    bit_idx = 3'(dx >> SCALE_LOG2);
    rd_char = SPACE;
    for (int l = 0; l < N_LINES; l++)
      for (int c = 0; c < CHARS_PER_LINE; c++)
        if (in_win && line == 3'(l) && col == 5'(c))
          rd_char = char_q[l][c];
    s1_valid_d  = s1_valid_q;
    s1_in_win_d = s1_in_win_q;
    s1_line_d   = s1_line_q;
    s1_bit_d    = s1_bit_q;
    s1_cur_d    = s1_cur_q;
    rom_addr_d  = rom_addr_q;
    if (pixel_tick) begin
      s1_valid_d  = 1'b1;
      s1_in_win_d = in_win;
      s1_line_d   = line;
      s1_bit_d    = bit_idx;
      s1_cur_d    = in_win && cur_en && (cur_line == line) && (cur_col == col);
      rom_addr_d  = {rd_char, row};
    end
  end

  // Combine the font row with colour, blink and cursor into the output pixel
  always_comb begin
    lcol     = 3'b000;
    blink_en = 1'b0;
    for (int l = 0; l < N_LINES; l++)
      if (s1_line_q == 3'(l)) begin
        lcol     = line_rgb[3*l +: 3];
        blink_en = line_blink[l];
      end
    font_bit   = font_word[3'd7 - s1_bit_q];
    text_on_d  = text_on_q;
    text_rgb_d = text_rgb_q;
    if (pixel_tick && s1_valid_q) begin
      if (!s1_in_win_q || (blink_en && !phase_q)) begin
        text_on_d  = 1'b0;
        text_rgb_d = 3'b000;
      end else if (s1_cur_q) begin
        text_on_d  = 1'b1;
        text_rgb_d = font_bit ? 3'b000 : lcol;
      end else begin
        text_on_d  = font_bit;
        text_rgb_d = font_bit ? lcol : 3'b000;
      end
    end
  end

  // Buffer and write-error state, written every clk regardless of pixel_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < N_LINES; l++)
        for (int c = 0; c < CHARS_PER_LINE; c++)
          char_q[l][c] <= SPACE;
      wr_err_q <= 1'b0;
    end else begin
      char_q   <= char_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Blink synchroniser and phase; phase starts visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      phase_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      phase_q <= phase_d;
    end
  end

  // Pixel pipeline registers, holding whenever pixel_tick is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_in_win_q <= 1'b0;
      s1_line_q   <= 3'd0;
      s1_bit_q    <= 3'd0;
      s1_cur_q    <= 1'b0;
      rom_addr_q  <= 11'd0;
      text_on_q   <= 1'b0;
      text_rgb_q  <= 3'b000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_in_win_q <= s1_in_win_d;
      s1_line_q   <= s1_line_d;
      s1_bit_q    <= s1_bit_d;
      s1_cur_q    <= s1_cur_d;
      rom_addr_q  <= rom_addr_d;
      text_on_q   <= text_on_d;
      text_rgb_q  <= text_rgb_d;
    end
  end

  assign wr_bus.wr_err = wr_err_q;
  assign rom_addr      = rom_addr_q;
  assign text_on       = text_on_q;
  assign text_rgb      = text_rgb_q;

endmodule

// File: tb/tb_tictactoe_text_overlay.sv
// Directed bench for tictactoe_text_overlay: one instance at default
// parameters and one at SCALE_LOG2=0, ORIGIN_X=100 for the window edges.
module tb_tictactoe_text_overlay;

  logic        clk = 1'b0;
  logic        rst_n, pixel_tick, clk1Hz, cur_en;
  logic [9:0]  pix_x, pix_y;
  logic [2:0]  cur_line;
  logic [4:0]  cur_col;
  logic [5:0]  line_rgb;
  logic [1:0]  line_blink;
  logic [7:0]  font1, font2;
  logic [10:0] addr1, addr2;
  logic        on1, on2;
  logic [2:0]  rgb1, rgb2;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          x;
    int          y;
    logic        on;
    logic [2:0]  rgb;
    logic [10:0] addr;
  } vec_t;

  vec_t vecs [12];

  tictactoe_text_overlay_if if1 ();
  tictactoe_text_overlay_if if2 ();

  tictactoe_text_overlay dut1 (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .pix_x(pix_x), .pix_y(pix_y),
    .clk1Hz(clk1Hz), .wr_bus(if1), .line_rgb(line_rgb), .line_blink(line_blink),
    .cur_en(cur_en), .cur_line(cur_line), .cur_col(cur_col), .font_word(font1),
    .rom_addr(addr1), .text_on(on1), .text_rgb(rgb1)
  );

  tictactoe_text_overlay #(.SCALE_LOG2(0), .ORIGIN_X(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .pix_x(pix_x), .pix_y(pix_y),
    .clk1Hz(clk1Hz), .wr_bus(if2), .line_rgb(line_rgb), .line_blink(line_blink),
    .cur_en(1'b0), .cur_line(cur_line), .cur_col(cur_col), .font_word(font2),
    .rom_addr(addr2), .text_on(on2), .text_rgb(rgb2)
  );

  always #5 clk = ~clk;

  // Toy font: spaces are blank, any other glyph alternates 8'h81 / 8'h3C by row
  function automatic logic [7:0] fontRom(input logic [10:0] a);
    if (a[10:4] == 7'h20) return 8'h00;
    return a[0] ? 8'h3C : 8'h81;
  endfunction

  always @(posedge clk) begin
    font1 <= fontRom(addr1);
    font2 <= fontRom(addr2);
  end

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tickPixel();
    @(negedge clk) pixel_tick = 1'b1;
    @(negedge clk) pixel_tick = 1'b0;
  endtask

  // Present a pixel for two ticks so its result reaches the outputs
  task automatic applyStimulus(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tickPixel();
    tickPixel();
  endtask

  task automatic writeBus(input int which, input int l, input int c, input logic [6:0] ch,
                          output logic err0, output logic err1);
    @(negedge clk);
    if (which == 0) begin
      if1.wr_en = 1'b1; if1.wr_line = 3'(l); if1.wr_col = 5'(c); if1.wr_char = ch;
    end else begin
      if2.wr_en = 1'b1; if2.wr_line = 3'(l); if2.wr_col = 5'(c); if2.wr_char = ch;
    end
    @(posedge clk); #1;
    err0 = (which == 0) ? if1.wr_err : if2.wr_err;
    @(negedge clk);
    if1.wr_en = 1'b0;
    if2.wr_en = 1'b0;
    @(posedge clk); #1;
    err1 = (which == 0) ? if1.wr_err : if2.wr_err;
  endtask

  task automatic blinkEdge(input logic level);
    @(negedge clk) clk1Hz = level;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic e0, e1;
    logic seen_on;

    vecs[0]  = '{32, 64, 1'b1, 3'b100, 11'h580};
    vecs[1]  = '{34, 64, 1'b0, 3'b000, 11'h580};
    vecs[2]  = '{47, 64, 1'b1, 3'b100, 11'h580};
    vecs[3]  = '{36, 66, 1'b1, 3'b100, 11'h581};
    vecs[4]  = '{34, 66, 1'b0, 3'b000, 11'h581};
    vecs[5]  = '{32, 95, 1'b0, 3'b000, 11'h58F};
    vecs[6]  = '{48, 64, 1'b0, 3'b000, 11'h200};
    vecs[7]  = '{31, 64, 1'b0, 3'b000, 11'h200};
    vecs[8]  = '{40, 63, 1'b0, 3'b000, 11'h20F};
    vecs[9]  = '{32, 128, 1'b0, 3'b000, 11'h200};
    vecs[10] = '{256, 64, 1'b0, 3'b000, 11'h200};
    vecs[11] = '{0, 96, 1'b1, 3'b010, 11'h410};

    rst_n = 1'b0; pixel_tick = 1'b0; clk1Hz = 1'b0; cur_en = 1'b0;
    cur_line = 3'd0; cur_col = 5'd0; pix_x = 10'd32; pix_y = 10'd64;
    line_rgb = 6'b010_100; line_blink = 2'b00;
    if1.wr_en = 1'b0; if1.wr_line = 3'd0; if1.wr_col = 5'd0; if1.wr_char = 7'd0;
    if2.wr_en = 1'b0; if2.wr_line = 3'd0; if2.wr_col = 5'd0; if2.wr_char = 7'd0;

    // Reset: pipeline frozen even with pixel ticks
    repeat (2) @(negedge clk);
    pixel_tick = 1'b1;
    repeat (2) @(negedge clk);
    pixel_tick = 1'b0;
    checkOutput("reset_rom_addr", addr1, 11'h000);
    checkOutput("reset_text_on", {10'b0, on1}, 11'd0);
    checkOutput("reset_wr_err", {10'b0, if1.wr_err}, 11'd0);
    @(negedge clk) rst_n = 1'b1;

    // Blank buffer: nothing painted anywhere in and around the window
    seen_on = 1'b0;
    for (int y = 60; y < 132; y += 6)
      for (int x = 0; x < 270; x += 10) begin
        applyStimulus(x, y);
        if (on1) seen_on = 1'b1;
      end
    checkOutput("blank_frame_text_on", {10'b0, seen_on}, 11'd0);

    // Buffer writes on the default instance
    writeBus(0, 0, 2, 7'h58, e0, e1);
    checkOutput("wr_ok_err", {9'b0, e0, e1}, 11'd0);
    writeBus(0, 1, 0, 7'h41, e0, e1);
    checkOutput("wr_ok2_err", {9'b0, e0, e1}, 11'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y);
      checkOutput($sformatf("vec%0d_on", i), {10'b0, on1}, {10'b0, vecs[i].on});
      checkOutput($sformatf("vec%0d_rgb", i), {8'b0, rgb1}, {8'b0, vecs[i].rgb});
      checkOutput($sformatf("vec%0d_addr", i), addr1, vecs[i].addr);
    end

    // Out-of-range writes: one-cycle error pulse, buffer untouched
    writeBus(0, 0, 20, 7'h41, e0, e1);
    checkOutput("wr_col_oor_err", {9'b0, e0, e1}, 11'b10);
    writeBus(0, 2, 2, 7'h41, e0, e1);
    checkOutput("wr_line_oor_err", {9'b0, e0, e1}, 11'b10);
    applyStimulus(64, 64);
    checkOutput("oor_col4_addr", addr1, 11'h200);
    applyStimulus(32, 64);
    checkOutput("oor_col2_addr", addr1, 11'h580);

    // Blink on line 1 only
    line_blink = 2'b10;
    blinkEdge(1'b1);
    applyStimulus(0, 96);
    checkOutput("blink_off_line1_on", {10'b0, on1}, 11'd0);
    checkOutput("blink_off_line1_rgb", {8'b0, rgb1}, 11'd0);
    applyStimulus(32, 64);
    checkOutput("blink_off_line0_on", {10'b0, on1}, 11'd1);
    blinkEdge(1'b0);
    blinkEdge(1'b1);
    applyStimulus(0, 96);
    checkOutput("blink_on_line1_on", {10'b0, on1}, 11'd1);
    checkOutput("blink_on_line1_rgb", {8'b0, rgb1}, 11'b010);

    // Cursor over a space and over the 'X'
    cur_en = 1'b1; cur_line = 3'd0; cur_col = 5'd5;
    applyStimulus(80, 64);
    checkOutput("cur_space_tl", {7'b0, on1, rgb1}, 11'b1100);
    applyStimulus(95, 95);
    checkOutput("cur_space_br", {7'b0, on1, rgb1}, 11'b1100);
    applyStimulus(96, 64);
    checkOutput("cur_next_cell", {7'b0, on1, rgb1}, 11'b0000);
    cur_col = 5'd2;
    applyStimulus(32, 64);
    checkOutput("cur_x_setbit", {7'b0, on1, rgb1}, 11'b1000);
    applyStimulus(34, 64);
    checkOutput("cur_x_clrbit", {7'b0, on1, rgb1}, 11'b1100);

    // Second instance: origin 100, scale 1, window edges
    writeBus(1, 0, 0, 7'h58, e0, e1);
    writeBus(1, 0, 15, 7'h58, e0, e1);
    applyStimulus(100, 64);
    checkOutput("d2_x100", {7'b0, on2, rgb2}, 11'b1100);
    checkOutput("d2_x100_addr", addr2, 11'h580);
    applyStimulus(101, 64);
    checkOutput("d2_x101", {10'b0, on2}, 11'd0);
    applyStimulus(99, 64);
    checkOutput("d2_x99", {10'b0, on2}, 11'd0);
    applyStimulus(227, 64);
    checkOutput("d2_x227", {10'b0, on2}, 11'd1);
    applyStimulus(228, 64);
    checkOutput("d2_x228", {10'b0, on2}, 11'd0);
    checkOutput("d2_x228_addr", addr2, 11'h200);

    // Mid-frame reset with cursor over X at (32,64): cleared immediately
    line_blink = 2'b00;
    clk1Hz = 1'b0;
    applyStimulus(32, 64);
    checkOutput("pre_reset_on", {10'b0, on1}, 11'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checkOutput("midreset_on", {10'b0, on1}, 11'd0);
    checkOutput("midreset_addr", addr1, 11'h000);
    @(negedge clk) rst_n = 1'b1;
    tickPixel();
    checkOutput("post_reset_tick1", {7'b0, on1, rgb1}, 11'b0000);
    checkOutput("post_reset_addr", addr1, 11'h200);
    tickPixel();
    checkOutput("post_reset_tick2", {7'b0, on1, rgb1}, 11'b1100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
